interrupt_sequencer: RTL and testbench

- Runs the 6502 reset, NMI, IRQ and BRK entry sequences for the CPU core.
- Pushes PCH, PCL and P onto the stack (page $01), then fetches the 16-bit vector.
- Drives the fetched vector onto the program counter's ADL/ADH load inputs with the load enables asserted. It is the writer side of the PC's address-bus load path.
- Sits between the PC, stack pointer, status register and the memory bus mux.

---
 rtl/interrupt_sequencer.sv | 168 ++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 6502 reset/NMI/IRQ/BRK entry sequencer driving the PC vector load
module interrupt_sequencer #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic        sys_clock,
    input  logic        rst,
    input  logic        CLOCK_ph2,
    input  logic        sync,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        brk_req,
    input  logic        i_flag,
    input  logic [7:0]  pcl_in,
    input  logic [7:0]  pch_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  data_in,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    output logic        rw,
    output logic        sp_dec,
    output logic [7:0]  ADLout,
    output logic [7:0]  ADHout,
    output logic        ADLin_en,
    output logic        ADHin_en,
    output logic        set_i,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_LO, VEC_HI, LOAD
    } state_t;

    typedef enum logic [1:0] {
        K_RST, K_NMI, K_BRK, K_IRQ
    } kind_t;

    state_t      state, state_nx;
    kind_t       kind, kind_nx;
    logic        rst_pend;
    logic        nmi_pend;
    logic        nmi_prev;
    logic [15:0] vec_addr;
    logic [7:0]  vec_lo;
    logic [7:0]  vec_hi;
    logic        nmi_fall;
    logic        start_req;
    logic        take_nmi;
    logic [15:0] vec_sel;
    logic [7:0]  push_byte;

    assign nmi_fall  = nmi_prev & ~nmi_n;
    assign start_req = sync & (nmi_pend | brk_req | (~irq_n & ~i_flag));

    // A pending NMI hijacks the vector of any non-reset sequence at VEC_LO entry.
    assign take_nmi = (state == PUSH_P) && (kind != K_RST) && nmi_pend;
    assign vec_sel  = (kind == K_RST) ? RST_VEC : (nmi_pend ? NMI_VEC : IRQ_VEC);

    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        case (state)
            IDLE: begin
                if (rst_pend) begin
                    state_nx = PUSH_H;
                    kind_nx  = K_RST;
                end else if (start_req) begin
                    state_nx = PUSH_H;
                    if (nmi_pend)
                        kind_nx = K_NMI;
                    else if (brk_req)
                        kind_nx = K_BRK;
                    else
                        kind_nx = K_IRQ;
                end
            end
            PUSH_H:  state_nx = PUSH_L;
            PUSH_L:  state_nx = PUSH_P;
            PUSH_P:  state_nx = VEC_LO;
            VEC_LO:  state_nx = VEC_HI;
            VEC_HI:  state_nx = LOAD;
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (!rst) begin
            state    <= IDLE;
            kind     <= K_RST;
            rst_pend <= 1'b1;
            nmi_pend <= 1'b0;
            nmi_prev <= 1'b1;
            vec_addr <= 16'h0000;
            vec_lo   <= 8'h00;
            vec_hi   <= 8'h00;
        end else begin
            nmi_prev <= nmi_n;
            if (CLOCK_ph2) begin
                state <= state_nx;
                kind  <= kind_nx;
                if (state == PUSH_P)
                    vec_addr <= vec_sel;
                if (state == VEC_LO)
                    vec_lo <= data_in;
                if (state == VEC_HI)
                    vec_hi <= data_in;
                if (state == LOAD)
                    rst_pend <= 1'b0;
            end
            // A fresh falling edge outranks the clear so a back-to-back NMI is not lost.
            if (nmi_fall)
                nmi_pend <= 1'b1;
            else if (CLOCK_ph2 && take_nmi)
                nmi_pend <= 1'b0;
        end
    end

    always_comb begin
        push_byte = 8'h00;
        case (state)
            PUSH_H:  push_byte = pch_in;
            PUSH_L:  push_byte = pcl_in;
            PUSH_P:  push_byte = {p_in[7:6], 1'b1, (kind == K_BRK), p_in[3:0]};
            default: push_byte = 8'h00;
        endcase
    end

    always_comb begin
        addr     = 16'h0000;
        data_out = 8'h00;
        rw       = 1'b1;
        sp_dec   = 1'b0;
        ADLout   = 8'h00;
        ADHout   = 8'h00;
        ADLin_en = 1'b0;
        ADHin_en = 1'b0;
        set_i    = 1'b0;
        busy     = 1'b1;
        if (rst) begin
            busy = (state != IDLE) || rst_pend;
            case (state)
                PUSH_H, PUSH_L, PUSH_P: begin
                    addr   = {8'h01, sp_in};
                    sp_dec = 1'b1;
                    // Reset entry walks the stack with dummy reads instead of writes.
                    if (kind != K_RST) begin
                        rw       = 1'b0;
                        data_out = push_byte;
                    end
                end
                VEC_LO: addr = vec_addr;
                VEC_HI: addr = vec_addr + 16'd1;
                LOAD: begin
                    ADLout   = vec_lo;
                    ADHout   = vec_hi;
                    ADLin_en = 1'b1;
                    ADHin_en = 1'b1;
                    set_i    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - scoreboard bench for interrupt_sequencer with a step-level reference model
module tb_interrupt_sequencer;

    logic        sys_clock = 1'b0;
    logic        rst = 1'b0;
    logic        CLOCK_ph2 = 1'b1;
    logic        sync = 1'b0;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        brk_req = 1'b0;
    logic        i_flag = 1'b0;
    logic [7:0]  pcl_in = 8'h00;
    logic [7:0]  pch_in = 8'h00;
    logic [7:0]  p_in = 8'h00;
    logic [7:0]  sp_in = 8'h00;
    logic [7:0]  data_in;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        rw;
    logic        sp_dec;
    logic [7:0]  ADLout;
    logic [7:0]  ADHout;
    logic        ADLin_en;
    logic        ADHin_en;
    logic        set_i;
    logic        busy;

    interrupt_sequencer dut (
        .sys_clock(sys_clock), .rst(rst), .CLOCK_ph2(CLOCK_ph2), .sync(sync),
        .nmi_n(nmi_n), .irq_n(irq_n), .brk_req(brk_req), .i_flag(i_flag),
        .pcl_in(pcl_in), .pch_in(pch_in), .p_in(p_in), .sp_in(sp_in),
        .data_in(data_in), .addr(addr), .data_out(data_out), .rw(rw),
        .sp_dec(sp_dec), .ADLout(ADLout), .ADHout(ADHout), .ADLin_en(ADLin_en),
        .ADHin_en(ADHin_en), .set_i(set_i), .busy(busy)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic [15:0] addr;
        logic        chk_addr;
        logic [7:0]  data;
        logic        chk_data;
        logic        rw;
        logic        sp_dec;
        logic [7:0]  adl;
        logic [7:0]  adh;
        logic        en;
        logic        set_i;
    } step_t;

    step_t      exp_q[$];
    int         checks = 0;
    int         passed = 0;
    logic       half_rate = 1'b0;
    logic [7:0] vec_mem [0:7];

    // Top six bytes of memory hold the vectors, indexed by the low address bits.
    always_comb begin
        data_in = 8'hEA;
        if (addr >= 16'hFFFA)
            data_in = vec_mem[addr[2:0]];
    end

    task automatic check(input string name, input logic ok, input string detail);
        checks++;
        if (ok)
            passed++;
        else
            $display("FAIL %s: %s", name, detail);
    endtask

    // kind: 0 reset, 1 NMI, 2 BRK, 3 IRQ
    task automatic expect_seq(input int kind, input logic [15:0] pc, input logic [7:0] p,
                              input logic [7:0] sp, input logic hijack);
        step_t       s;
        logic [15:0] v;
        logic [7:0]  pushed [0:2];
        logic [7:0]  s8;
        pushed[0] = pc[15:8];
        pushed[1] = pc[7:0];
        pushed[2] = ((p | 8'h20) & 8'hEF) | ((kind == 2) ? 8'h10 : 8'h00);
        s = '{addr: 16'h0, chk_addr: 1'b1, data: 8'h0, chk_data: 1'b1, rw: 1'b1,
              sp_dec: 1'b0, adl: 8'h0, adh: 8'h0, en: 1'b0, set_i: 1'b0};
        if (kind == 0)
            exp_q.push_back(s);
        for (int i = 0; i < 3; i++) begin
            s8 = sp - 8'(i);
            s.addr = {8'h01, s8};
            s.data = (kind == 0) ? 8'h00 : pushed[i];
            s.rw = (kind == 0);
            s.sp_dec = 1'b1;
            exp_q.push_back(s);
        end
        v = (kind == 0) ? 16'hFFFC : ((kind == 1 || hijack) ? 16'hFFFA : 16'hFFFE);
        s.sp_dec = 1'b0;
        s.rw = 1'b1;
        s.chk_data = 1'b0;
        s.addr = v;
        exp_q.push_back(s);
        s.addr = v + 16'd1;
        exp_q.push_back(s);
        s.chk_addr = 1'b0;
        s.adl = vec_mem[v[2:0]];
        s.adh = vec_mem[3'(v[2:0] + 3'd1)];
        s.en = 1'b1;
        s.set_i = 1'b1;
        exp_q.push_back(s);
    endtask

    // Monitor plus stack-pointer emulation: sample mid-cycle, apply SP decrement after the edge.
    initial begin
        step_t e;
        logic  dec;
        logic  ok;
        forever begin
            @(negedge sys_clock);
            dec = rst && CLOCK_ph2 && sp_dec;
            if (!rst) begin
                check("reset_outputs",
                      addr == 16'h0 && data_out == 8'h0 && rw && !sp_dec && ADLout == 8'h0 &&
                      ADHout == 8'h0 && !ADLin_en && !ADHin_en && !set_i && busy,
                      $sformatf("got addr=%h data=%h rw=%b spdec=%b adl=%h adh=%h en=%b%b seti=%b busy=%b required all idle and busy=1",
                                addr, data_out, rw, sp_dec, ADLout, ADHout, ADLin_en, ADHin_en, set_i, busy));
            end else if (CLOCK_ph2 && busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_step", 1'b0,
                          $sformatf("got busy step addr=%h rw=%b en=%b required idle", addr, rw, ADLin_en));
                end else begin
                    e = exp_q.pop_front();
                    ok = (!e.chk_addr || addr == e.addr) && (!e.chk_data || data_out == e.data) &&
                         rw == e.rw && sp_dec == e.sp_dec && ADLout == e.adl && ADHout == e.adh &&
                         ADLin_en == e.en && ADHin_en == e.en && set_i == e.set_i;
                    check("seq_step", ok,
                          $sformatf("got addr=%h data=%h rw=%b spdec=%b adl=%h adh=%h en=%b%b seti=%b required addr=%h data=%h rw=%b spdec=%b adl=%h adh=%h en=%b seti=%b",
                                    addr, data_out, rw, sp_dec, ADLout, ADHout, ADLin_en, ADHin_en, set_i,
                                    e.addr, e.data, e.rw, e.sp_dec, e.adl, e.adh, e.en, e.set_i));
                end
            end else if (CLOCK_ph2 && (!rw || ADLin_en || ADHin_en)) begin
                check("stray_bus", 1'b0,
                      $sformatf("got rw=%b en=%b%b while idle required rw=1 en=00", rw, ADLin_en, ADHin_en));
            end
            @(posedge sys_clock);
            #1;
            if (dec)
                sp_in = sp_in - 8'd1;
        end
    end

    task automatic tick();
        @(posedge sys_clock);
        #2;
        CLOCK_ph2 = half_rate ? ~CLOCK_ph2 : 1'b1;
    endtask

    task automatic wait_enabled_edge();
        logic en;
        do begin
            en = CLOCK_ph2;
            tick();
        end while (!en);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check(name, exp_q.size() == 0, $sformatf("got %0d steps outstanding required 0", exp_q.size()));
        exp_q.delete();
        tick();
        tick();
        check({name, "_idle"}, !busy && rw, $sformatf("got busy=%b rw=%b required busy=0 rw=1", busy, rw));
    endtask

    task automatic reset_release(input logic [7:0] sp);
        sp_in = sp;
        rst = 1'b1;
        expect_seq(0, 16'h0, 8'h0, sp, 1'b0);
        drain("reset_seq");
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        sync = 1'b0;
        brk_req = 1'b0;
        irq_n = 1'b1;
        nmi_n = 1'b1;
        repeat (3) tick();
    endtask

    // abort: pull reset while the sequence is in VEC_HI, then run the reset entry.
    task automatic run_seq(input int kind, input logic [15:0] pc, input logic [7:0] p,
                           input logic [7:0] sp, input logic hijack, input logic hold_low,
                           input logic abort);
        int n;
        pch_in = pc[15:8];
        pcl_in = pc[7:0];
        p_in = p;
        sp_in = sp;
        if (kind == 1) begin
            nmi_n = 1'b0;
            tick();
        end
        brk_req = (kind == 2) || (kind == 1 && $urandom_range(1) == 1);
        if (kind == 3) begin
            irq_n = 1'b0;
            i_flag = 1'b0;
        end else begin
            irq_n = ($urandom_range(1) == 1);
            i_flag = ($urandom_range(1) == 1);
        end
        expect_seq(kind, pc, p, sp, hijack);
        sync = 1'b1;
        wait_enabled_edge();
        sync = 1'b0;
        brk_req = 1'b0;
        irq_n = 1'b1;
        nmi_n = 1'b1;
        if (hijack) begin
            n = 0;
            while (exp_q.size() > 5 && n < 20) begin
                tick();
                n++;
            end
            nmi_n = 1'b0;
            tick();
            if (!hold_low)
                nmi_n = 1'b1;
        end
        if (abort) begin
            n = 0;
            while (exp_q.size() > 2 && n < 40) begin
                tick();
                n++;
            end
            check("abort_reached_vec_hi", exp_q.size() == 2,
                  $sformatf("got %0d steps outstanding required 2", exp_q.size()));
            rst = 1'b0;
            exp_q.delete();
            repeat (3) tick();
            reset_release(8'hFD);
        end else begin
            drain("int_seq");
        end
        if (hold_low) begin
            sync = 1'b1;
            repeat (10) tick();
            sync = 1'b0;
            check("nmi_low_no_retrigger", !busy, $sformatf("got busy=%b required 0", busy));
            nmi_n = 1'b1;
            tick();
        end
    endtask

    task automatic directed_set();
        apply_reset();
        vec_mem[4] = 8'h34;
        vec_mem[5] = 8'h12;
        reset_release(8'hFD);
        run_seq(3, 16'hC123, 8'h20, 8'hFF, 1'b0, 1'b0, 1'b0);
        i_flag = 1'b1;
        irq_n = 1'b0;
        sync = 1'b1;
        repeat (20) tick();
        check("irq_masked", !busy, $sformatf("got busy=%b required 0", busy));
        sync = 1'b0;
        irq_n = 1'b1;
        i_flag = 1'b0;
        run_seq(2, 16'h8000, 8'hC3, 8'hF0, 1'b0, 1'b0, 1'b0);
        run_seq(3, 16'h4455, 8'h01, 8'h80, 1'b1, 1'b1, 1'b0);
        run_seq(1, 16'h0102, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        run_seq(3, 16'hBEEF, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int kind;
        for (int i = 0; i < 8; i++)
            vec_mem[i] = 8'($urandom);
        directed_set();
        half_rate = 1'b1;
        directed_set();
        for (int r = 0; r < 24; r++) begin
            half_rate = ($urandom_range(1) == 1);
            for (int i = 2; i < 8; i++)
                vec_mem[i] = 8'($urandom);
            kind = $urandom_range(3, 1);
            run_seq(kind, 16'($urandom), 8'($urandom), 8'($urandom),
                    (kind != 1) && ($urandom_range(1) == 1), 1'b0, ($urandom_range(7) == 0));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
